// File: rtl/audio_sample_fifo_if.sv
// Handshake and stream-control bundle between the audio sample FIFO and its
// neighbours. The NeXT-side receiver and the I2S sender both connect through
// this interface. The FIFO itself uses the slave modport.
interface audio_sample_fifo_if;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        start_in;
    logic        end_in;
    logic        mode_22k_in;
    logic        req_tick;
    logic        req_mode;
    logic        out_valid;
    logic [31:0] out_data;
    logic        audio_start_out;
    logic        audio_end_out;
    logic        audio_22k_out;
    logic        fetch_req;

    modport master (
        output wr_valid, wr_data, start_in, end_in, mode_22k_in, req_tick, req_mode,
        input  wr_ready, out_valid, out_data, audio_start_out, audio_end_out,
               audio_22k_out, fetch_req
    );

    modport slave (
        input  wr_valid, wr_data, start_in, end_in, mode_22k_in, req_tick, req_mode,
        output wr_ready, out_valid, out_data, audio_start_out, audio_end_out,
               audio_22k_out, fetch_req
    );
endinterface

// File: rtl/audio_sample_fifo.sv
// Sample buffer and stream controller feeding the I2S sender.
// Stereo words (L in [31:16], R in [15:0]) are queued in a small FIFO and
// handed out one per sender request tick. The IDLE/RUN/DRAIN sequencer emits
// the start/end/rate pulses, asks upstream for refill below the low-water
// mark, and counts underruns. An empty FIFO answers with silence in RUN.
module audio_sample_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int LOW_WATER  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    audio_sample_fifo_if.slave    bus,
    output logic [DEPTH_LOG2:0]   level,
    output logic [7:0]            underrun_cnt
);

    localparam int DEPTH   = 2 ** DEPTH_LOG2;
    localparam int LEVEL_W = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = LEVEL_W'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LEVEL_LOW  = LEVEL_W'(LOW_WATER);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level_next;

    logic full;
    logic empty;
    logic do_write;
    logic tick;
    logic do_pop;
    logic do_underrun;
    logic start_go;
    logic end_go;

    // Occupancy flags and the write handshake. The reset term keeps wr_ready
    // low while reset is held, so every output reads 0 during reset.
    assign full          = (level == LEVEL_FULL);
    assign empty         = (level == '0);
    assign bus.wr_ready  = rst_n && !full && (state != DRAIN);
    assign do_write      = bus.wr_valid && bus.wr_ready;

    // A tick only counts when the sender is in request mode and a stream is
    // active. A pop reads only words that were present before this edge.
    assign tick        = bus.req_tick && bus.req_mode && (state != IDLE);
    assign do_pop      = tick && !empty;
    assign do_underrun = tick && empty && (state == RUN);

    // Hold the stream sequencer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Work out the next sequencer state and which control pulses fire.
    always_comb begin
        state_next = state;
        start_go   = 1'b0;
        end_go     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_in && !bus.end_in) begin
                    state_next = RUN;
                    start_go   = 1'b1;
                end
            end
            RUN: begin
                if (bus.end_in) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (empty && !do_pop) begin
                    state_next = IDLE;
                    end_go     = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Occupancy after this edge. A simultaneous write and pop cancel out.
    always_comb begin
        level_next = level;
        case ({do_write, do_pop})
            2'b10:   level_next = level + LEVEL_W'(1);
            2'b01:   level_next = level - LEVEL_W'(1);
            default: level_next = level;
        endcase
    end

    // Sample storage. It is never flushed because an empty level is enough.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // Advance the read and write pointers and track occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            level <= level_next;
        end
    end

    // Register the sender-side outputs, the refill request and the underrun count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid       <= 1'b0;
            bus.out_data        <= '0;
            bus.audio_start_out <= 1'b0;
            bus.audio_end_out   <= 1'b0;
            bus.audio_22k_out   <= 1'b0;
            bus.fetch_req       <= 1'b0;
            underrun_cnt        <= '0;
        end else begin
            bus.out_valid       <= do_pop || do_underrun;
            bus.audio_start_out <= start_go;
            bus.audio_end_out   <= end_go;
            bus.fetch_req       <= (state_next == RUN) && (level_next < LEVEL_LOW);
            if (do_pop) begin
                bus.out_data <= mem[rd_ptr];
            end else if (do_underrun) begin
                bus.out_data <= '0;
            end
            if (start_go) begin
                bus.audio_22k_out <= bus.mode_22k_in;
                underrun_cnt      <= '0;
            end else if (do_underrun && (underrun_cnt != 8'hFF)) begin
                underrun_cnt <= underrun_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Randomised scoreboard bench for audio_sample_fifo. The stimulus side keeps a
// queue-based reference of the stream and pushes expected pulses tagged with
// the cycle they are due. A separate monitor pops and compares them.
module tb_audio_sample_fifo;

    localparam int DEPTH_LOG2 = 3;
    localparam int DEPTH      = 8;
    localparam int LOW_WATER  = 2;

    localparam int K_OUT   = 0;
    localparam int K_START = 1;
    localparam int K_END   = 2;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic [DEPTH_LOG2:0] level;
    logic [7:0]          underrun_cnt;

    audio_sample_fifo_if bus();

    audio_sample_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .LOW_WATER  (LOW_WATER)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .level        (level),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    exp_t        exp_q[$];
    logic [31:0] model_q[$];
    int          m_state;
    int          m_under;
    logic        m_fetch;
    logic        m_22k;
    logic [31:0] m_last;

    // Count the rising edges so that expected pulses can carry a due cycle.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic matchEvent(input int kind, input logic [31:0] data, input string name);
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc || exp_q[0].kind != kind) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got unexpected pulse (data %0h) expected none (cycle %0d)", name, data, cyc);
        end else begin
            checkOutput(name, data, exp_q[0].data);
            void'(exp_q.pop_front());
        end
    endtask

    // Monitor: compare every pulse against the scoreboard and flag overdue entries.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL missing_pulse: got no pulse expected kind %0d data %0h (cycle %0d)",
                     exp_q[0].kind, exp_q[0].data, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (bus.out_valid)       matchEvent(K_OUT, bus.out_data, "out_sample");
        if (bus.audio_start_out) matchEvent(K_START, {31'b0, bus.audio_22k_out}, "start_pulse");
        if (bus.audio_end_out)   matchEvent(K_END, 32'd0, "end_pulse");
    end

    task automatic modelReset();
        model_q.delete();
        exp_q.delete();
        m_state = S_IDLE;
        m_under = 0;
        m_fetch = 1'b0;
        m_22k   = 1'b0;
        m_last  = '0;
    endtask

    task automatic pushExp(input int kind, input logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_level"},    32'(level), 32'd0);
        checkOutput({tag, "_underrun"}, 32'(underrun_cnt), 32'd0);
        checkOutput({tag, "_fetch"},    32'(bus.fetch_req), 32'd0);
        checkOutput({tag, "_outvalid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_outdata"},  bus.out_data, 32'd0);
        checkOutput({tag, "_start"},    32'(bus.audio_start_out), 32'd0);
        checkOutput({tag, "_end"},      32'(bus.audio_end_out), 32'd0);
        checkOutput({tag, "_22k"},      32'(bus.audio_22k_out), 32'd0);
        checkOutput({tag, "_wrready"},  32'(bus.wr_ready), 32'd0);
    endtask

    // One clock cycle: drive inputs, predict from the stream rules, step, check status.
    task automatic applyStimulus(input logic wv, input logic [31:0] wd, input logic st,
                                 input logic en, input logic m22, input logic tk, input logic rm);
        int   pre_size;
        logic accept;
        logic served;
        logic popped;
        bus.wr_valid    = wv;
        bus.wr_data     = wd;
        bus.start_in    = st;
        bus.end_in      = en;
        bus.mode_22k_in = m22;
        bus.req_tick    = tk;
        bus.req_mode    = rm;

        pre_size = model_q.size();
        accept   = wv && (pre_size < DEPTH) && (m_state != S_DRAIN);
        served   = tk && rm && (m_state != S_IDLE);
        popped   = 1'b0;
        if (served && pre_size > 0) begin
            m_last = model_q.pop_front();
            popped = 1'b1;
            pushExp(K_OUT, m_last);
        end else if (served && m_state == S_RUN) begin
            m_last = '0;
            if (m_under < 255) m_under++;
            pushExp(K_OUT, 32'd0);
        end
        case (m_state)
            S_IDLE: if (st && !en) begin
                m_state = S_RUN;
                m_under = 0;
                m_22k   = m22;
                pushExp(K_START, {31'b0, m22});
            end
            S_RUN: if (en) m_state = S_DRAIN;
            default: if (pre_size == 0 && !popped) begin
                m_state = S_IDLE;
                pushExp(K_END, 32'd0);
            end
        endcase
        if (accept) model_q.push_back(wd);
        m_fetch = (m_state == S_RUN) && (model_q.size() < LOW_WATER);

        @(posedge clk);
        @(negedge clk);
        checkOutput("level",        32'(level), 32'(model_q.size()));
        checkOutput("fetch_req",    32'(bus.fetch_req), 32'(m_fetch));
        checkOutput("underrun_cnt", 32'(underrun_cnt), 32'(m_under));
        checkOutput("wr_ready",     32'(bus.wr_ready), 32'(model_q.size() < DEPTH && m_state != S_DRAIN));
        checkOutput("out_data_hold", bus.out_data, m_last);
        checkOutput("rate_latch",   32'(bus.audio_22k_out), 32'(m_22k));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        bus.wr_valid = 1'b0; bus.start_in = 1'b0; bus.end_in = 1'b0;
        bus.req_tick = 1'b0; bus.req_mode = 1'b0; bus.mode_22k_in = 1'b0;
        #2 rst_n = 1'b0;
        #1 checkAllZero("midreset");
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        modelReset();
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.start_in = 1'b0; bus.end_in = 1'b0;
        bus.mode_22k_in = 1'b0; bus.req_tick = 1'b0; bus.req_mode = 1'b0;
        #1 checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Prefill A, B, C in IDLE, then start a 22 kHz stream.
        applyStimulus(1'b1, 32'hAAAA_1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hBBBB_2222, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'hCCCC_3333, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(1);

        // Four back-to-back ticks: A, B, C, then one underrun.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Refill two words, then a tick with req_mode low must be ignored.
        applyStimulus(1'b1, 32'h0101_0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0202_0202, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Fill to full, offer one more word, pop one, then write and tick together.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h7777_7777, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Pop down to two words, end the stream, drain both, tick once more on empty.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idleCycles(3);

        // Start and end pulsed together in IDLE: nothing happens.
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idleCycles(1);

        // Random traffic across all states.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 19) == 0),
                          1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) != 0));
        end

        // Bring the stream back to IDLE with the FIFO emptied.
        for (int i = 0; i < 40 && !(m_state == S_IDLE && model_q.size() == 0); i++) begin
            if (m_state == S_IDLE) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            else                   applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        end
        idleCycles(2);

        // Saturate the underrun counter with 300 ticks on an empty RUN stream.
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("underrun_saturated", 32'(underrun_cnt), 32'd255);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(3);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("underrun_cleared", 32'(underrun_cnt), 32'd0);

        // Reset in the middle of a running stream with data buffered.
        applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h9ABC_DEF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        doReset();
        idleCycles(2);
        applyStimulus(1'b1, 32'hFACE_CAFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idleCycles(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drained: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
